// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and helpers for the instruction fetch unit.
//   fetch_state_t   - fetch FSM state encoding
//   INSTR_BYTES     - size of one instruction word in bytes (PC increment)
//   is_word_aligned - true when an address sits on a 4-byte boundary
package fetch_pkg;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

  typedef enum logic [2:0] {
    ST_REQUEST  = 3'd0,
    ST_WAIT_RSP = 3'd1,
    ST_HOLD     = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_FAULT    = 3'd4
  } fetch_state_t;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC, fetches one word at a time from
// instruction memory (single outstanding read) and hands each word with its
// PC to the decoder, holding it until accepted. Handles redirects and faults.
//
// Ports:
//   clk_i, rst_ni                        clock, async active-low reset
//   mem_req_valid_o/ready_i/addr_o       read request channel (addr = PC)
//   mem_rsp_valid_i/data_i/error_i       read response channel
//   instruction_o/instruction_pc_o/
//   instruction_valid_o, decode_ready_i  decoder hand-off
//   redirect_valid_i, redirect_pc_i      one-cycle PC change request
//   fetch_fault_o, fault_pc_o            fault level and faulting PC
//
// Every output is a flop; output next-values are decoded from the next state,
// so no input reaches an output without passing through a register.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_req_addr_o,
  input  logic        mem_rsp_valid_i,
  input  logic [31:0] mem_rsp_data_i,
  input  logic        mem_rsp_error_i,
  output logic [31:0] instruction_o,
  output logic [31:0] instruction_pc_o,
  output logic        instruction_valid_o,
  input  logic        decode_ready_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        fetch_fault_o,
  output logic [31:0] fault_pc_o
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         pending_q, pending_d;
  logic         req_valid_q, req_valid_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic         instr_valid_q, instr_valid_d;
  logic         fault_q, fault_d;
  logic [31:0]  fault_pc_q, fault_pc_d;

  logic         req_hs_s;
  logic         rsp_s;

  // Handshake and response qualification; a response with nothing
  // outstanding (e.g. left over from before a reset) is ignored.
  always_comb begin
    req_hs_s = req_valid_q & mem_req_ready_i;
    rsp_s    = mem_rsp_valid_i & pending_q;
  end

  // Outstanding-read tracking.
  always_comb begin
    pending_d = pending_q;
    if (req_hs_s) begin
      pending_d = 1'b1;
    end else if (mem_rsp_valid_i) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // Fetch FSM, PC and captured data; a redirect overrides every other event.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    fault_pc_d = fault_pc_q;
    if (redirect_valid_i) begin
      if (!is_word_aligned(redirect_pc_i)) begin
        state_d    = ST_FAULT;
        fault_pc_d = redirect_pc_i;
      end else begin
        pc_d = redirect_pc_i;
        // pending_d already includes a handshake happening this cycle
        state_d = pending_d ? ST_DRAIN : ST_REQUEST;
      end
    end else begin
      case (state_q)
        ST_REQUEST: begin
          if (req_hs_s) begin
            state_d = ST_WAIT_RSP;
          end else begin
            state_d = ST_REQUEST;
          end
        end
        ST_WAIT_RSP: begin
          if (rsp_s) begin
            if (mem_rsp_error_i) begin
              state_d    = ST_FAULT;
              fault_pc_d = pc_q;
            end else begin
              state_d    = ST_HOLD;
              instr_d    = mem_rsp_data_i;
              instr_pc_d = pc_q;
            end
          end else begin
            state_d = ST_WAIT_RSP;
          end
        end
        ST_HOLD: begin
          if (decode_ready_i) begin
            pc_d    = pc_q + INSTR_BYTES;  // wraps modulo 2^32
            state_d = ST_REQUEST;
          end else begin
            state_d = ST_HOLD;
          end
        end
        ST_DRAIN: begin
          // stale response is dropped; nothing pending means nothing to drop
          if (rsp_s || !pending_q) begin
            state_d = ST_REQUEST;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_REQUEST;
        end
      endcase
    end
  end

  // Registered output decode from the next state.
  always_comb begin
    req_valid_d   = (state_d == ST_REQUEST);
    instr_valid_d = (state_d == ST_HOLD);
    fault_d       = (state_d == ST_FAULT);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_REQUEST;
      pc_q          <= RESET_PC;
      pending_q     <= 1'b0;
      req_valid_q   <= 1'b0;
      instr_q       <= 32'h0000_0000;
      instr_pc_q    <= 32'h0000_0000;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      fault_pc_q    <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pending_q     <= pending_d;
      req_valid_q   <= req_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      fault_q       <= fault_d;
      fault_pc_q    <= fault_pc_d;
    end
  end

  assign mem_req_valid_o     = req_valid_q;
  assign mem_req_addr_o      = pc_q;
  assign instruction_o       = instr_q;
  assign instruction_pc_o    = instr_pc_q;
  assign instruction_valid_o = instr_valid_q;
  assign fetch_fault_o       = fault_q;
  assign fault_pc_o          = fault_pc_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: the bench plays instruction memory and
// decoder, and tracks the expected fetch behaviour with a transaction-level
// model (expected PC, held instruction, fault, one in-flight read slot).
module tb_instruction_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i = 1'b0;
  logic [31:0] mem_req_addr_o;
  logic        mem_rsp_valid_i = 1'b0;
  logic [31:0] mem_rsp_data_i = 32'h0;
  logic        mem_rsp_error_i = 1'b0;
  logic [31:0] instruction_o;
  logic [31:0] instruction_pc_o;
  logic        instruction_valid_o;
  logic        decode_ready_i = 1'b0;
  logic        redirect_valid_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        fetch_fault_o;
  logic [31:0] fault_pc_o;

  instruction_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .mem_req_valid_o    (mem_req_valid_o),
    .mem_req_ready_i    (mem_req_ready_i),
    .mem_req_addr_o     (mem_req_addr_o),
    .mem_rsp_valid_i    (mem_rsp_valid_i),
    .mem_rsp_data_i     (mem_rsp_data_i),
    .mem_rsp_error_i    (mem_rsp_error_i),
    .instruction_o      (instruction_o),
    .instruction_pc_o   (instruction_pc_o),
    .instruction_valid_o(instruction_valid_o),
    .decode_ready_i     (decode_ready_i),
    .redirect_valid_i   (redirect_valid_i),
    .redirect_pc_i      (redirect_pc_i),
    .fetch_fault_o      (fetch_fault_o),
    .fault_pc_o         (fault_pc_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // stimulus knobs for the next cycle
  logic        k_ready = 1'b1, k_dr = 1'b1, k_redir = 1'b0, k_stray = 1'b0, k_err = 1'b0;
  int          k_lat = 1;
  logic [31:0] k_rpc = 32'h0, k_err_addr = 32'h1;

  // reference model
  logic [31:0] m_pc = RST_PC, m_held_pc = 32'h0, m_fault_pc = 32'h0;
  logic        m_held = 1'b0, m_fault = 1'b0, fresh = 1'b1;
  logic        slot_act = 1'b0, slot_live = 1'b0;
  int          slot_cnt = 0;
  logic [31:0] slot_addr = 32'h0;
  int          hs_count = 0;
  logic [31:0] last_hs_addr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_0F96;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) begin
      n_pass = n_pass + 1;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic want);
    n_checks++;
    assert (obs === want) begin
      n_pass = n_pass + 1;
    end else begin
      $error("FAIL %s: observed %b expected %b", tag, obs, want);
    end
  endtask

  task automatic default_knobs();
    k_ready = 1'b1; k_lat = 1; k_dr = 1'b1; k_redir = 1'b0;
    k_stray = 1'b0; k_err = 1'b0; k_err_addr = 32'h1;
  endtask

  // One clock cycle: check outputs against the model, drive inputs, advance.
  task automatic step();
    logic hs, rsp_now, rsp_live, err_now;
    logic [31:0] hs_addr;
    check1("req_valid", mem_req_valid_o, !fresh && !m_held && !m_fault && !slot_act);
    check1("fetch_fault", fetch_fault_o, m_fault);
    if (m_fault) check("fault_pc", fault_pc_o, m_fault_pc);
    check1("instr_valid", instruction_valid_o, m_held);
    if (m_held) begin
      check("instr_pc", instruction_pc_o, m_held_pc);
      check("instr", instruction_o, mem_word(m_held_pc));
    end
    rsp_now  = slot_act ? (slot_cnt == 0) : k_stray;
    err_now  = k_err || (slot_act && slot_addr == k_err_addr);
    rsp_live = rsp_now && slot_act && slot_live;
    mem_rsp_valid_i  = rsp_now;
    mem_rsp_data_i   = slot_act ? mem_word(slot_addr) : $urandom();
    mem_rsp_error_i  = rsp_now && err_now;
    mem_req_ready_i  = k_ready;
    decode_ready_i   = k_dr;
    redirect_valid_i = k_redir;
    redirect_pc_i    = k_rpc;
    hs      = mem_req_valid_o && k_ready;
    hs_addr = mem_req_addr_o;
    if (hs) begin
      check("req_addr", mem_req_addr_o, m_pc);
      hs_count++;
      last_hs_addr = mem_req_addr_o;
    end
    @(posedge clk);
    #1;
    fresh = 1'b0;
    if (k_redir) begin
      if (k_rpc[1:0] != 2'b00) begin
        m_fault = 1'b1; m_fault_pc = k_rpc;
      end else begin
        m_fault = 1'b0; m_pc = k_rpc;
      end
      m_held = 1'b0;
    end else begin
      if (m_held && k_dr) begin
        m_held = 1'b0; m_pc = m_pc + 32'd4;
      end
      if (rsp_live) begin
        if (err_now) begin
          m_fault = 1'b1; m_fault_pc = slot_addr;
        end else begin
          m_held = 1'b1; m_held_pc = slot_addr;
        end
      end
    end
    if (slot_act) begin
      if (rsp_now) slot_act = 1'b0;
      else slot_cnt--;
    end
    if (k_redir) slot_live = 1'b0;
    if (hs) begin
      slot_act = 1'b1; slot_cnt = k_lat - 1; slot_addr = hs_addr; slot_live = !k_redir;
    end
  endtask

  task automatic do_reset();
    mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rsp_error_i = 1'b0;
    decode_ready_i = 1'b0; redirect_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    check1("rst_req_valid", mem_req_valid_o, 1'b0);
    check("rst_req_addr", mem_req_addr_o, RST_PC);
    check("rst_instr", instruction_o, 32'h0);
    check("rst_instr_pc", instruction_pc_o, 32'h0);
    check1("rst_instr_valid", instruction_valid_o, 1'b0);
    check1("rst_fault", fetch_fault_o, 1'b0);
    check("rst_fault_pc", fault_pc_o, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_pc = RST_PC; m_held = 1'b0; m_fault = 1'b0; fresh = 1'b1;
    slot_act = 1'b0; slot_live = 1'b0;
  endtask

  task automatic step_until_hs(input int budget);
    int h0;
    h0 = hs_count;
    for (int i = 0; i < budget && hs_count == h0; i++) step();
    check1("hs_timeout", hs_count != h0, 1'b1);
  endtask

  initial begin
    int h0;
    default_knobs();
    #2;
    do_reset();

    // streaming: 0x100, 0x104, 0x108 one every 3 cycles
    hs_count = 0;
    for (int i = 0; i < 9; i++) step();
    check("t1_hs_count", hs_count, 32'd3);
    check("t1_last_addr", last_hs_addr, 32'h0000_0108);

    // decoder stall in HOLD, then release
    do_reset();
    k_dr = 1'b0;
    for (int i = 0; i < 20 && !m_held; i++) step();
    check1("t2_hold_reached", instruction_valid_o, 1'b1);
    repeat (5) step();
    check("t2_stable_pc", instruction_pc_o, 32'h0000_0100);
    k_dr = 1'b1;
    step_until_hs(12);
    check("t2_next_addr", last_hs_addr, 32'h0000_0104);

    // redirect while waiting; stale response lands 3 cycles later
    k_lat = 4;
    step_until_hs(12);
    k_redir = 1'b1; k_rpc = 32'h0000_2000;
    step();
    k_redir = 1'b0; k_lat = 1;
    step_until_hs(12);
    check("t3_redirect_addr", last_hs_addr, 32'h0000_2000);
    repeat (4) step();

    // bus error at 0x10C, then recover via redirect to 0
    do_reset();
    k_err_addr = 32'h0000_010C;
    for (int i = 0; i < 40 && !m_fault; i++) step();
    check1("t4_fault", fetch_fault_o, 1'b1);
    check("t4_fault_pc", fault_pc_o, 32'h0000_010C);
    h0 = hs_count;
    repeat (4) step();
    check("t4_no_req", hs_count, h0);
    k_err_addr = 32'h1;
    k_redir = 1'b1; k_rpc = 32'h0;
    step();
    k_redir = 1'b0;
    check1("t4_fault_clear", fetch_fault_o, 1'b0);
    step_until_hs(12);
    check("t4_resume_addr", last_hs_addr, 32'h0);

    // misaligned redirect
    k_redir = 1'b1; k_rpc = 32'h0000_2002;
    step();
    k_redir = 1'b0;
    check1("t5_fault", fetch_fault_o, 1'b1);
    check("t5_fault_pc", fault_pc_o, 32'h0000_2002);
    h0 = hs_count;
    repeat (4) step();
    check("t5_no_req", hs_count, h0);

    // PC wrap-around
    k_redir = 1'b1; k_rpc = 32'hFFFF_FFFC;
    step();
    k_redir = 1'b0;
    step_until_hs(12);
    check("t6_top_addr", last_hs_addr, 32'hFFFF_FFFC);
    step_until_hs(12);
    check("t6_wrap_addr", last_hs_addr, 32'h0);
    check1("t6_no_fault", fetch_fault_o, 1'b0);

    // reset mid-transaction, stray response afterwards is ignored
    k_lat = 5;
    step_until_hs(12);
    step();
    do_reset();
    k_stray = 1'b1;
    step();
    k_stray = 1'b0; k_dr = 1'b0;
    for (int i = 0; i < 20 && !m_held; i++) step();
    check1("t7_hold_after_reset", instruction_valid_o, 1'b1);
    check("t7_instr_pc", instruction_pc_o, RST_PC);
    k_dr = 1'b1;
    step();

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      k_ready = ($urandom_range(9) < 7);
      k_lat   = int'($urandom_range(3, 1));
      k_dr    = ($urandom_range(9) < 6);
      k_err   = ($urandom_range(19) == 0);
      k_redir = ($urandom_range(19) == 0);
      case ($urandom_range(7))
        0:       k_rpc = ($urandom() & 32'h0000_3FFC) | 32'h0000_0002;
        1:       k_rpc = 32'hFFFF_FFF8;
        default: k_rpc = $urandom() & 32'h0000_3FFC;
      endcase
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Produces the 32-bit instruction word consumed by the instruction decoder. It owns the program counter and issues word reads to instruction memory over a valid/ready request channel with a single outstanding read. It presents each fetched word with its PC to the decode stage and holds it until the decoder accepts it. It also handles control-flow redirects and fetch faults.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset; must be word-aligned.
- Clock  input  1  single clock; all state updates on rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- MemReqValid  output  1  read request valid.
- MemReqReady  input  1  memory accepts request this cycle.
- MemReqAddr  output  32  word-aligned read address (= PC).
- MemRspValid  input  1  read data valid; exactly one per accepted request, ≥1 cycle after acceptance.
- MemRspData  input  32  read data.
- MemRspError  input  1  bus error qualifying MemRspValid.
- Instruction  output  32  fetched word to decoder.
- InstructionPc  output  32  PC of Instruction.
- InstructionValid  output  1  Instruction/InstructionPc valid.
- DecodeReady  input  1  decoder accepts the presented instruction.
- RedirectValid  input  1  one-cycle request to change PC.
- RedirectPc  input  32  new PC.
- FetchFault  output  1  level; fetch stopped on a fault.
- FaultPc  output  32  PC that faulted.

## Operation
- States: REQUEST, WAIT_RSP, HOLD, DRAIN, FAULT. Reset state is REQUEST with PC = RESET_PC.
- Pending flag:
  - Set on a request handshake (MemReqValid & MemReqReady).
  - Cleared on MemRspValid.
  - Never more than one outstanding read.
- REQUEST: MemReqValid=1, MemReqAddr=PC. On MemReqReady, go to WAIT_RSP.
- WAIT_RSP: on MemRspValid:
  - Error=0: latch Instruction=MemRspData, InstructionPc=PC, go to HOLD.
  - Error=1: go to FAULT with FaultPc=PC.
- HOLD: InstructionValid=1, Instruction and InstructionPc stable. On DecodeReady, PC ← PC+4 and go to REQUEST.
- DRAIN: waits for the pending response, discards it (data and error), then goes to REQUEST.
- FAULT:
  - FetchFault=1; no requests issued.
  - Any late response is discarded and clears Pending.
  - Exit only on an aligned redirect.
- Redirect has priority over every other event in every state:
  - RedirectPc[1:0]≠0: go to FAULT, FaultPc=RedirectPc.
  - Otherwise: PC ← RedirectPc, InstructionValid and FetchFault cleared next cycle. Next state is DRAIN if Pending (including a request handshake in the same cycle), else REQUEST.
- Redirect in HOLD with DecodeReady in the same cycle: the decoder's acceptance stands. PC takes RedirectPc, not PC+4.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no fault.

## Timing
- Reset values:
  - MemReqValid=0, MemReqAddr=RESET_PC.
  - Instruction=0, InstructionPc=0, InstructionValid=0.
  - FetchFault=0, FaultPc=0.
  - Pending=0.
- First MemReqValid=1 in the first cycle after Reset_n deasserts.
- All outputs are registered or decoded from state only; no combinational path from any input to any output.
- Latency: with MemReqReady=1 and a 1-cycle response, InstructionValid rises 2 cycles after MemReqValid rises. Sustained throughput with DecodeReady=1 is one instruction per 3 cycles.
- MemReqValid, once raised, stays high with a stable address until MemReqReady, unless a redirect arrives. On redirect, the address changes next cycle.
- Reset asserted mid-transaction: all state cleared immediately. A response arriving after reset release with Pending=0 is ignored.

## Structure
- Shared package `fetch_pkg`:
  - State enum fetch_state_t.
  - INSTR_BYTES=4 constant.
  - Alignment-check function.
- Single module, no sub-modules. The PC register, pending flag and FSM are all in instruction_fetch_unit.

## Test plan
- Reset with RESET_PC=32'h0000_0100, memory always ready, 1-cycle latency, DecodeReady=1 → addresses 0x100, 0x104, 0x108 issued. InstructionPc matches each address, one instruction every 3 cycles.
- DecodeReady=0 for 5 cycles in HOLD → Instruction and InstructionPc stable, MemReqValid=0 throughout. Release → next address 0x104.
- Redirect to 32'h0000_2000 during WAIT_RSP, old response returns 3 cycles later → old data never shown, next request address 0x2000.
- MemRspError=1 on PC 0x10C → FetchFault=1, FaultPc=0x10C, no further requests. Redirect to 0x0 → fault clears, fetch resumes at 0x0.
- Redirect to 32'h0000_2002 → FetchFault=1, FaultPc=0x2002, no request issued.
- PC=32'hFFFF_FFFC accepted → next request address 32'h0000_0000, FetchFault stays 0.
